// File: rtl/multibus_pkg.sv
// multibus_pkg: shared FSM states, geometry helpers and counter width for multibus_cache_ctrl
package multibus_pkg;
  typedef enum logic [1:0] {IDLE, LOOKUP, MEM, DONE} state_t;
  localparam int CNT_W = 16;
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction
  function automatic int tag_w(input int aw, input int lines);
    return aw - $clog2(lines);
  endfunction
endpackage

// File: rtl/multibus_cache_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin grant over a request vector; the pointer moves past the winner on advance
module rr_arbiter #(
  parameter int NPORTS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NPORTS-1:0]         req,
  input  logic                      advance,
  output logic [NPORTS-1:0]         grant,
  output logic [$clog2(NPORTS)-1:0] grant_idx
);
  localparam int PW = $clog2(NPORTS);
  logic [PW-1:0] ptr;
  logic found;
  always_comb begin
    found = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NPORTS; i++)
      if (!found && req[PW'((int'(ptr) + i) % NPORTS)]) begin
        found = 1'b1;
        grant_idx = PW'((int'(ptr) + i) % NPORTS);
      end
    grant = NPORTS'(found) << grant_idx;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (advance) ptr <= grant_idx == PW'(NPORTS - 1) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/multibus_cache_ctrl.sv
// multibus_cache_ctrl: N-port round-robin front end to a direct-mapped write-through cache and backing memory.
// Define MULTIBUS_STATS_EN to add saturating read hit/miss counters.
module multibus_cache_ctrl
  import multibus_pkg::*;
#(
  parameter int NPORTS  = 2,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int LINES   = 16,
  parameter int MEM_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORTS-1:0]    start,
  input  logic [NPORTS-1:0]    write_op,
  input  logic [NPORTS*AW-1:0] in_address,
  input  logic [NPORTS*DW-1:0] in_data,
  output logic [NPORTS*DW-1:0] out_data,
  output logic [NPORTS-1:0]    finish_flag,
  output logic                 read_busy,
  output logic                 write_busy
`ifdef MULTIBUS_STATS_EN
  ,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count
`endif
);
  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(AW, LINES);
  localparam int PW = $clog2(NPORTS);
  localparam int CW = $clog2(MEM_LAT + 1);
  state_t state;
  logic [NPORTS-1:0] pend, pend_wr, grant;
  logic [AW-1:0] pend_addr [NPORTS];
  logic [DW-1:0] pend_data [NPORTS];
  logic [PW-1:0] gidx, cur;
  logic cur_wr, advance, hit;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  logic [CW-1:0] cnt;
  logic [LINES-1:0] line_valid;
  logic [TW-1:0] line_tag [LINES];
  logic [DW-1:0] line_data [LINES];
  logic [DW-1:0] mem [2**AW];
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  assign advance = state == IDLE && |pend;
  assign idx = cur_addr[IW-1:0];
  assign tag = cur_addr[AW-1:IW];
  assign hit = line_valid[idx] && line_tag[idx] == tag;
  rr_arbiter #(.NPORTS(NPORTS)) u_arb (
    .clk(clk), .rst(rst), .req(pend), .advance(advance), .grant(grant), .grant_idx(gidx)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pend <= '0;
      pend_wr <= '0;
      for (int p = 0; p < NPORTS; p++) begin
        pend_addr[p] <= '0;
        pend_data[p] <= '0;
      end
      cur <= '0;
      cur_wr <= 1'b0;
      cur_addr <= '0;
      cur_data <= '0;
      cnt <= '0;
      line_valid <= '0;
      for (int l = 0; l < LINES; l++) begin
        line_tag[l] <= '0;
        line_data[l] <= '0;
      end
      for (int m = 0; m < 2**AW; m++) mem[m] <= '0;
      out_data <= '0;
      finish_flag <= '0;
      read_busy <= 1'b0;
      write_busy <= 1'b0;
`ifdef MULTIBUS_STATS_EN
      hit_count <= '0;
      miss_count <= '0;
`endif
    end else begin
      // a slot being granted this cycle is still pending, so a start on it is dropped
      for (int p = 0; p < NPORTS; p++)
        if (advance && grant[p]) pend[p] <= 1'b0;
        else if (start[p] && !pend[p]) begin
          pend[p] <= 1'b1;
          pend_wr[p] <= write_op[p];
          pend_addr[p] <= in_address[p*AW +: AW];
          pend_data[p] <= in_data[p*DW +: DW];
        end
      case (state)
        IDLE:
          if (advance) begin
            cur <= gidx;
            cur_wr <= pend_wr[gidx];
            cur_addr <= pend_addr[gidx];
            cur_data <= pend_data[gidx];
            read_busy <= !pend_wr[gidx];
            write_busy <= pend_wr[gidx];
            state <= LOOKUP;
          end
        LOOKUP: begin
          cnt <= '0;
`ifdef MULTIBUS_STATS_EN
          if (!cur_wr && hit) hit_count <= hit_count + CNT_W'(hit_count != '1);
          if (!cur_wr && !hit) miss_count <= miss_count + CNT_W'(miss_count != '1);
`endif
          if (!cur_wr && hit) begin
            out_data[cur*DW +: DW] <= line_data[idx];
            finish_flag[cur] <= 1'b1;
            state <= DONE;
          end else state <= MEM;
        end
        MEM:
          if (cnt == CW'(MEM_LAT - 1)) begin
            line_valid[idx] <= 1'b1;
            line_tag[idx] <= tag;
            line_data[idx] <= cur_wr ? cur_data : mem[cur_addr];
            if (cur_wr) mem[cur_addr] <= cur_data;
            else out_data[cur*DW +: DW] <= mem[cur_addr];
            finish_flag[cur] <= 1'b1;
            state <= DONE;
          end else cnt <= cnt + 1'b1;
        default: begin
          finish_flag <= '0;
          read_busy <= 1'b0;
          write_busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_multibus_cache_ctrl.sv
// tb_multibus_cache_ctrl: directed and randomized checks against a transaction-timing reference model
module tb_multibus_cache_ctrl;
  import multibus_pkg::*;
  localparam int N = 4, AW = 8, DW = 8, LINES = 16, LAT = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] start = '0, write_op = '0, finish_flag;
  logic [N*AW-1:0] in_address = '0;
  logic [N*DW-1:0] in_data = '0, out_data;
  logic read_busy, write_busy;
`ifdef MULTIBUS_STATS_EN
  logic [CNT_W-1:0] hit_count, miss_count;
  int m_hit, m_miss;
`endif
  multibus_cache_ctrl #(.NPORTS(N), .AW(AW), .DW(DW), .LINES(LINES), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .write_op(write_op), .in_address(in_address),
    .in_data(in_data), .out_data(out_data), .finish_flag(finish_flag),
    .read_busy(read_busy), .write_busy(write_busy)
`ifdef MULTIBUS_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [DW-1:0] mm [256];
  bit cv [LINES];
  int ct [LINES];
  bit [N-1:0] mpend;
  bit pw [N];
  int pa [N];
  logic [DW-1:0] pd [N];
  int rr, mcur, mrem;
  bit mbusy, mwr;
  logic [DW-1:0] mval;
  logic [N-1:0] exp_ff;
  logic [N*DW-1:0] exp_out;
  logic exp_rb, exp_wb;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int a = 0; a < 256; a++) mm[a] = '0;
    for (int l = 0; l < LINES; l++) begin cv[l] = 0; ct[l] = 0; end
    mpend = '0; rr = 0; mbusy = 0; mrem = 0;
    exp_ff = '0; exp_out = '0; exp_rb = 0; exp_wb = 0;
`ifdef MULTIBUS_STATS_EN
    m_hit = 0; m_miss = 0;
`endif
  endtask
  // advances the model across one clock edge using the inputs of the current cycle
  task automatic model_step();
    bit [N-1:0] pre;
    int g, a;
    bit hit;
    pre = mpend;
    exp_ff = '0;
    if (mbusy) begin
      if (mrem == 0) begin mbusy = 0; exp_rb = 0; exp_wb = 0; end
      else begin
        mrem--;
        if (mrem == 0) begin
          exp_ff[mcur] = 1'b1;
          if (!mwr) exp_out[mcur*DW +: DW] = mval;
        end
      end
    end else if (|mpend) begin
      g = -1;
      for (int i = 0; i < N; i++) if (g < 0 && mpend[(rr + i) % N]) g = (rr + i) % N;
      mpend[g] = 0; rr = (g + 1) % N; a = pa[g];
      hit = !pw[g] && cv[a % LINES] && ct[a % LINES] == a / LINES;
`ifdef MULTIBUS_STATS_EN
      if (!pw[g]) begin if (hit) m_hit++; else m_miss++; end
`endif
      if (pw[g]) mm[a] = pd[g];
      cv[a % LINES] = 1; ct[a % LINES] = a / LINES;
      mval = mm[a]; mwr = pw[g]; mcur = g; mbusy = 1;
      mrem = hit ? 1 : 1 + LAT;
      exp_rb = !mwr; exp_wb = mwr;
    end
    for (int p = 0; p < N; p++)
      if (start[p] && !pre[p]) begin
        mpend[p] = 1; pw[p] = write_op[p]; pa[p] = int'(in_address[p*AW +: AW]); pd[p] = in_data[p*DW +: DW];
      end
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    start = '0;
    chk("finish_flag", 64'(finish_flag), 64'(exp_ff));
    chk("out_data", 64'(out_data), 64'(exp_out));
    chk("read_busy", 64'(read_busy), 64'(exp_rb));
    chk("write_busy", 64'(write_busy), 64'(exp_wb));
  endtask
  task automatic issue(input int p, input bit wr, input int a, input int d);
    start[p] = 1'b1;
    write_op[p] = wr;
    in_address[p*AW +: AW] = AW'(a);
    in_data[p*DW +: DW] = DW'(d);
  endtask
  task automatic wait_fin(input int p, output int n);
    n = 0;
    do begin tick(); n++; end while (!finish_flag[p] && n < 40);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    start = '0;
    model_reset();
    #1;
    chk("rst_ff", 64'(finish_flag), 0);
    chk("rst_out", 64'(out_data), 0);
    chk("rst_busy", 64'({read_busy, write_busy}), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    int n, order;
    int nstart [N], nfin [N];
    int addrs [6];
    model_reset();
    @(negedge clk);
    do_reset();
    issue(0, 0, 5, 0);
    wait_fin(0, n);
    chk("lat_read_miss", 64'(n), 64'(3 + LAT));
    issue(0, 0, 5, 0);
    wait_fin(0, n);
    chk("lat_read_hit", 64'(n), 3);
    chk("hit_data0", 64'(out_data[0 +: DW]), 0);
    issue(0, 1, 5, 1);
    tick();
    tick();
    chk("wbusy_mid_write", 64'(write_busy), 1);
    wait_fin(0, n);
    chk("lat_write", 64'(n), 64'(1 + LAT));
    issue(1, 0, 5, 0);
    wait_fin(1, n);
    chk("lat_hit_after_write", 64'(n), 3);
    chk("read_after_write", 64'(out_data[DW +: DW]), 1);
    issue(1, 1, 5, 2);
    issue(0, 0, 5, 0);
    wait_fin(0, n);
    chk("rr_first_data", 64'(out_data[0 +: DW]), 1);
    chk("rr_second_pending", 64'(finish_flag[1]), 0);
    wait_fin(1, n);
    chk("rr_second_done", 64'(finish_flag[1]), 1);
    issue(0, 0, 5, 0);
    wait_fin(0, n);
    chk("reread_data", 64'(out_data[0 +: DW]), 2);
    issue(0, 1, 9, 8'h55);
    tick();
    tick();
    tick();
    chk("wbusy_in_mem", 64'(write_busy), 1);
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    issue(2, 0, 9, 0);
    wait_fin(2, n);
    chk("read_after_reset", 64'(out_data[2*DW +: DW]), 0);
    do_reset();
    order = 0;
    for (int p = 0; p < N; p++) begin issue(p, 0, p * 3, 0); nstart[p] = 1; nfin[p] = 0; end
    for (int c = 0; c < 300 && order < 3 * N; c++) begin
      tick();
      for (int p = 0; p < N; p++)
        if (finish_flag[p]) begin
          chk("rr_order", 64'(p), 64'(order % N));
          order++;
          nfin[p]++;
          if (nstart[p] < 3) begin issue(p, 0, p * 3, 0); nstart[p]++; end
        end
    end
    for (int p = 0; p < N; p++) chk("fin_vs_start", 64'(nfin[p]), 64'(nstart[p]));
    addrs = '{5, 21, 37, 9, 200, 0};
    for (int c = 0; c < 1500; c++) begin
      addrs[5] = $urandom_range(0, 255);
      for (int p = 0; p < N; p++)
        if ($urandom_range(0, 3) == 0) issue(p, 1'($urandom_range(0, 1)), addrs[$urandom_range(0, 5)], $urandom_range(0, 255));
      tick();
    end
    for (int c = 0; c < 60; c++) tick();
`ifdef MULTIBUS_STATS_EN
    chk("hit_count", 64'(hit_count), 64'(m_hit));
    chk("miss_count", 64'(miss_count), 64'(m_miss));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
